// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC command path (feeder and engine).
package cordic_pkg;
  localparam int IO_BW_DEF  = 32;
  localparam int MODE_W_DEF = 3;

  typedef struct packed {
    logic [IO_BW_DEF-1:0]  phase;
    logic [MODE_W_DEF-1:0] mode;
  } cmd_t;

  localparam logic [MODE_W_DEF-1:0] MODE_CIRC_ROT = 3'd0;
  localparam logic [MODE_W_DEF-1:0] MODE_CIRC_VEC = 3'd1;
  localparam logic [MODE_W_DEF-1:0] MODE_LIN_ROT  = 3'd2;
  localparam logic [MODE_W_DEF-1:0] MODE_LIN_VEC  = 3'd3;
  localparam logic [MODE_W_DEF-1:0] MODE_HYP_ROT  = 3'd4;
endpackage

// File: rtl/cordic_cmd_fifo_mem.sv
// Command FIFO storage: one registered write port, combinational head read.
module cordic_cmd_fifo_mem #(
  parameter int W     = 35,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cordic_cmd_feeder.sv
// Buffers host {phase, mode} commands and presents them to the CORDIC engine,
// freezing the presented command while the engine stalls.
module cordic_cmd_feeder
  import cordic_pkg::*;
#(
  parameter int IO_BW  = IO_BW_DEF,
  parameter int MODE_W = MODE_W_DEF,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [IO_BW-1:0]           wr_phase,
  input  logic [MODE_W-1:0]          wr_mode,
  output logic                       full,
  input  logic                       flush,
  input  logic                       pop,
  output logic [IO_BW-1:0]           phase,
  output logic [MODE_W-1:0]          mode,
  output logic                       valid_in,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = IO_BW + MODE_W;

  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d, ovf_q, ovf_d, valid_q, valid_d;
  logic [IO_BW-1:0]  phase_q, phase_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     head;
  logic              push, rd, nonempty;

  // full is the registered flag, so a push at level==DEPTH is refused even
  // when a read frees a slot on the same edge.
  assign nonempty = (level_q != '0);
  assign push     = wr_en && !full_q && !flush;
  assign rd       = !pop && nonempty && !flush;

  cordic_cmd_fifo_mem #(.W(CW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i ({wr_phase, wr_mode}),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q + LW'(push) - LW'(rd);
    ovf_d   = ovf_q | (wr_en & full_q);
    cnt_d   = cnt_q + CNT_W'(valid_q & ~pop);
    valid_d = valid_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    if (!pop) begin
      valid_d = nonempty;
      if (nonempty) {phase_d, mode_d} = head;
    end
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      valid_d = 1'b0;
      phase_d = '0;
      mode_d  = '0;
    end
    full_d = (level_d == LW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      phase_q <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign full       = full_q;
  assign overflow   = ovf_q;
  assign valid_in   = valid_q;
  assign phase      = phase_q;
  assign mode       = mode_q;
  assign level      = level_q;
  assign issued_cnt = cnt_q;
endmodule

// File: doc/cordic_cmd_feeder.md
Name: cordic_cmd_feeder

Overview:
- Upstream command buffer for cordic_engine.
- Accepts {phase, mode} commands from the host or pattern source at up to one per cycle, and queues them in a FIFO.
- Drives the engine's phase/mode/valid_in registers, holding them whenever the engine asserts pop (stall).
- Decouples host burstiness from engine back-pressure; provides occupancy, overflow and issued-count status.

Parameters:
- IO_BW, 32, width of phase (matches engine IO_BW).
- MODE_W, 3, width of mode field.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of issued-command counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  host push strobe.
- wr_phase  in  IO_BW  command phase.
- wr_mode  in  MODE_W  command mode.
- full  out  1  FIFO full; a push is accepted only when full==0.
- flush  in  1  synchronous clear of FIFO and output stage.
- pop  in  1  engine stall; 1 = hold outputs.
- phase  out  IO_BW  to engine.
- mode  out  MODE_W  to engine.
- valid_in  out  1  to engine; qualifies phase/mode.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, excluding the output stage.
- overflow  out  1  sticky; set by a push attempted while full.
- issued_cnt  out  CNT_W  number of commands presented with valid_in=1 and accepted (pop==0).

Behaviour:
- Reset and flush: synchronous; reset when rst_n==0 at a rising edge.
  - Reset clears: level=0, full=0, valid_in=0, phase=0, mode=0, overflow=0, issued_cnt=0, pointers=0.
  - flush==1 clears the same state except overflow and issued_cnt. A push in a flush cycle is dropped.
  - Reset mid-operation discards all queued and presented commands.
- Push:
  - wr_en && !full writes {wr_phase, wr_mode} at the write pointer. The pointer wraps modulo DEPTH.
  - wr_en && full: data is dropped and overflow is set to 1. It stays 1 until reset.
- Issue (output stage is a register stage):
  - pop==1: phase, mode and valid_in hold. The FIFO is not read. issued_cnt holds.
  - pop==0 and level>0: load head into phase/mode, set valid_in=1, advance the read pointer.
  - pop==0 and level==0: valid_in=0; phase/mode hold their last values.
  - issued_cnt increments at each edge where valid_in==1 and pop==0, i.e. the engine consumed the presented command. It wraps at 2^CNT_W.
- Simultaneous push and read:
  - level is unchanged; both pointers advance.
  - full is computed from pre-edge level only. A push at level==DEPTH is rejected even if a read happens the same cycle (no bypass).
- Latency: a push at edge t into an empty FIFO with pop==0 appears with valid_in=1 after edge t+1.
- Flow: with pop held 0 and no starvation, one command is issued per cycle, in strict push order.
- full = (level==DEPTH), registered and updated at the same edge as level.
- Commands are never reordered, duplicated or lost, except by overflow drop, flush or reset.

Decomposition:
- Package cordic_pkg:
  - IO_BW / MODE_W defaults.
  - Command struct typedef cmd_t {phase, mode}.
  - Mode encoding constants shared with cordic_engine.
- One sub-module, cordic_cmd_fifo_mem:
  - DEPTH x (IO_BW+MODE_W) register array.
  - Write port plus combinational head read.
- The feeder owns pointers, level, flags, output stage and counter.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with wr_en=1 -> valid_in=0, level=0, full=0, overflow=0, issued_cnt=0 after release.
2. Streaming: push 5 commands (phase=0x0000_1000*k, mode=k%5) with pop=0 -> valid_in high for 5 consecutive cycles starting one cycle after the first push, exact order, issued_cnt=5.
3. Back-pressure: 3 commands queued, pop=1 for 4 cycles -> phase/mode/valid_in frozen on command 0 and level=2. After pop drops, commands 1 and 2 follow on consecutive cycles; issued_cnt=3.
4. Full/overflow: pop=1, push 9 with DEPTH=8 -> full=1 after the 8th push (level=8, output stage still empty), 9th dropped, overflow=1. Drain yields exactly the first 8 commands.
5. Simultaneous push/read at level=3 with pop=0 -> level stays 3; at level=8 push is rejected even with a read that cycle.
6. Flush with 4 queued and valid_in=1 -> next cycle valid_in=0, level=0, full=0; overflow and issued_cnt unchanged. A new push issues normally, wrapping the pointers past DEPTH.
